// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key-code table, FSM encoding and LFSR taps for the keypad model and scanner.
package keypad_pkg;
    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    // {row[1:0], col[1:0]}, zero-based, indexed by key code
    localparam logic [3:0] KEY_POS [16] = '{
        4'hC, 4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8,
        4'h9, 4'hA, 4'h3, 4'h7, 4'hB, 4'hF, 4'hE, 4'hD
    };
endpackage

// File: rtl/keypad_matrix_model_if.sv
// keypad_matrix_model_if: press/release command handshake into the keypad model.
interface keypad_matrix_model_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_key;
    logic       cmd_press;
    modport master (output cmd_valid, cmd_key, cmd_press, input cmd_ready);
    modport slave (input cmd_valid, cmd_key, cmd_press, output cmd_ready);
endinterface

// File: rtl/keypad_matrix_model_lfsr16.sv
// kpm_lfsr16: 16-bit Galois LFSR that supplies contact chatter while enabled.
module kpm_lfsr16
    import keypad_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [15:0] state_o
);
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= SEED;
        else if (en_i)
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    end
    assign state_o = lfsr_q;
endmodule

// File: rtl/keypad_matrix_model.sv
// keypad_matrix_model: 4x4 keypad emulator driving active-low rows from scanner column strobes,
// with LFSR-modelled contact bounce on each press/release.
module keypad_matrix_model
    import keypad_pkg::*;
#(
    parameter logic [19:0] BOUNCE_CYCLES = 20'd16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic [3:0]                  iCOL,
    output logic [3:0]                  oROW,
    keypad_matrix_model_if.slave        cmd,
    output logic [15:0]                 oKEYMAP,
    output logic                        oBUSY,
    output logic                        oSETTLED
);
    state_t      state_q, state_d;
    logic [3:0]  key_q, key_d;
    logic        press_q, press_d;
    logic [19:0] cnt_q, cnt_d;
    logic [15:0] keymap_q, keymap_d;
    logic [3:0]  row_q, row_d;
    logic        settled_q, settled_d;
    logic        ready_q, busy_q;
    logic [15:0] lfsr, contact;
    logic        accept;

    kpm_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (iCLK),
        .rst_n  (iRST),
        .en_i   (state_q == BOUNCE),
        .state_o(lfsr)
    );

    assign accept = cmd.cmd_valid & ready_q;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        press_d   = press_q;
        cnt_d     = cnt_q;
        keymap_d  = keymap_q;
        settled_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                key_d   = cmd.cmd_key;
                press_d = cmd.cmd_press;
                if (cmd.cmd_press == keymap_q[cmd.cmd_key] || BOUNCE_CYCLES == 20'd0) begin
                    keymap_d[cmd.cmd_key] = cmd.cmd_press;
                    settled_d             = 1'b1;
                end else begin
                    state_d = BOUNCE;
                    cnt_d   = BOUNCE_CYCLES - 20'd1;
                end
            end
            BOUNCE: begin
                state_d = (cnt_q == 20'd0) ? SETTLE : BOUNCE;
                cnt_d   = (cnt_q == 20'd0) ? cnt_q : cnt_q - 20'd1;
            end
            SETTLE: begin
                keymap_d[key_q] = press_q;
                settled_d       = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The chattering key follows LFSR bit0; all other keys show their settled state.
    always_comb begin
        contact = keymap_q;
        if (state_q == BOUNCE)
            contact[key_q] = lfsr[0];
        row_d = 4'b1111;
        for (int k = 0; k < 16; k++)
            if (contact[k] && !iCOL[KEY_POS[k][1:0]])
                row_d[KEY_POS[k][3:2]] = 1'b0;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q   <= IDLE;
            key_q     <= 4'h0;
            press_q   <= 1'b0;
            cnt_q     <= 20'd0;
            keymap_q  <= 16'h0000;
            row_q     <= 4'b1111;
            settled_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
            keymap_q  <= keymap_d;
            row_q     <= row_d;
            settled_q <= settled_d;
            ready_q   <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign oROW          = row_q;
    assign oKEYMAP       = keymap_q;
    assign oBUSY         = busy_q;
    assign oSETTLED      = settled_q;
    assign cmd.cmd_ready = ready_q;
endmodule

// File: tb/tb_keypad_matrix_model.sv
// tb_keypad_matrix_model: directed scoreboard bench for a clean (no bounce) and a bouncing keypad model.
module tb_keypad_matrix_model;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col = 4'b0000;
    logic [3:0]  row0, row1;
    logic [15:0] map0, map1;
    logic        busy0, busy1, set0, set1;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] m0 = 16'h0000;
    logic [15:0] m1 = 16'h0000;

    keypad_matrix_model_if c0();
    keypad_matrix_model_if c1();

    keypad_matrix_model #(.BOUNCE_CYCLES(20'd0)) dut0 (
        .iCLK(clk), .iRST(rst_n), .iCOL(col), .oROW(row0), .cmd(c0),
        .oKEYMAP(map0), .oBUSY(busy0), .oSETTLED(set0)
    );
    keypad_matrix_model dut1 (
        .iCLK(clk), .iRST(rst_n), .iCOL(col), .oROW(row1), .cmd(c1),
        .oKEYMAP(map1), .oBUSY(busy1), .oSETTLED(set1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Scoreboard: every settle pulse must match the oldest outstanding expected keymap.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (set0) begin
                if (q0.size() == 0) chk("unexpected_settle0", 1, 0);
                else chk("settle_map0", map0, q0.pop_front());
            end
            if (set1) begin
                if (q1.size() == 0) chk("unexpected_settle1", 1, 0);
                else chk("settle_map1", map1, q1.pop_front());
            end
        end
    end

    task automatic send(input bit sel, input logic [3:0] k, input logic p);
        int n = 0;
        if (sel) begin
            c1.cmd_key = k; c1.cmd_press = p; c1.cmd_valid = 1'b1;
            m1[k] = p; q1.push_back(m1);
        end else begin
            c0.cmd_key = k; c0.cmd_press = p; c0.cmd_valid = 1'b1;
            m0[k] = p; q0.push_back(m0);
        end
        while (!(sel ? c1.cmd_ready : c0.cmd_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", n, 0);
        @(posedge clk);
        #1;
        c0.cmd_valid = 1'b0;
        c1.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] l;
        int bc;
        c0.cmd_valid = 1'b0; c0.cmd_key = 4'h0; c0.cmd_press = 1'b0;
        c1.cmd_valid = 1'b0; c1.cmd_key = 4'h0; c1.cmd_press = 1'b0;
        #19;
        chk("rst_row0", row0, 4'b1111);
        chk("rst_row1", row1, 4'b1111);
        chk("rst_map1", map1, 16'h0000);
        chk("rst_ready1", c1.cmd_ready, 0);
        #1 rst_n = 1'b1;
        #1 chk("ready_before_clk", c1.cmd_ready, 0);
        @(negedge clk);
        chk("ready_after_clk0", c0.cmd_ready, 1);
        chk("ready_after_clk1", c1.cmd_ready, 1);

        send(0, 4'h0, 1'b1);
        @(negedge clk);
        chk("clean_settle_pulse", set0, 1);
        chk("clean_busy", busy0, 0);
        @(negedge clk);
        chk("clean_settle_one_cycle", set0, 0);
        col = 4'b1110;
        @(negedge clk);
        chk("clean_row_col1", row0, 4'b0111);
        col = 4'b1101;
        @(negedge clk);
        chk("clean_row_col2", row0, 4'b1111);

        send(1, 4'h8, 1'b1);
        l = 16'hACE1;
        bc = 0;
        for (int j = 0; j <= 16; j++) begin
            @(negedge clk);
            bc += int'(busy1);
            chk("bounce_ready_low", c1.cmd_ready, 0);
            if (j > 0) begin
                chk("bounce_row", row1, {1'b1, ~l[0], 2'b11});
                l = lfsr_next(l);
            end
        end
        @(negedge clk);
        chk("bounce_busy_done", busy1, 0);
        chk("bounce_busy_cycles", bc, 17);
        @(negedge clk);
        chk("bounce_final_row", row1, 4'b1011);
        chk("bounce_final_map", map1, 16'h0100);

        send(1, 4'h8, 1'b0); wait_idle();
        send(1, 4'h6, 1'b1); wait_idle();
        send(1, 4'hA, 1'b1); wait_idle();
        col = 4'b0000;
        @(negedge clk);
        chk("multi_row", row1, 4'b1100);
        send(1, 4'hA, 1'b0); wait_idle();
        @(negedge clk);
        chk("release_row", row1, 4'b1101);
        chk("release_map", map1, 16'h0040);

        send(1, 4'h6, 1'b1);
        @(negedge clk);
        chk("redundant_busy", busy1, 0);
        chk("redundant_settle", set1, 1);
        @(negedge clk);
        chk("redundant_settle_one_cycle", set1, 0);
        chk("redundant_map", map1, 16'h0040);

        send(1, 4'h5, 1'b1);
        repeat (5) @(negedge clk);
        chk("midbounce_busy", busy1, 1);
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        m0 = 16'h0000; m1 = 16'h0000;
        #1;
        chk("abort_row", row1, 4'b1111);
        chk("abort_map", map1, 16'h0000);
        chk("abort_busy", busy1, 0);
        chk("abort_ready", c1.cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("scoreboard0_drained", q0.size(), 0);
        chk("scoreboard1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_model.md
Name: keypad_matrix_model

Overview:
- Synthesizable 4x4 keypad matrix emulator: the key-matrix side of the row/column scan interface.
- Accepts key press/release commands, models contact bounce with an LFSR, and drives active-low row lines in response to the scanner's active-low column strobes.
- Used in benches and in hardware-in-loop builds in place of a physical keypad, wired back-to-back with the keypad scanner (scanner column output -> iCOL, oROW -> scanner row input).

Parameters:
- BOUNCE_CYCLES, 20'd16, number of chatter cycles after a state change; 0 means clean transitions.
- LFSR_SEED, 16'hACE1, reset seed of the bounce LFSR; must be non-zero.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  reset, asynchronous, active-low
- iCOL  in  4  column strobes from scanner, active-low; bit0 = column 1
- oROW  out  4  row sense lines to scanner, active-low; bit0 = row 1
- iCMD_VALID  in  1  command valid
- oCMD_READY  out  1  model can accept a command
- iCMD_KEY  in  4  key code (same encoding as scanner key number low nibble)
- iCMD_PRESS  in  1  1 = press, 0 = release
- oKEYMAP  out  16  settled contact state per key code, bit k = key k held
- oBUSY  out  1  transition (bounce) in progress
- oSETTLED  out  1  one-cycle pulse when a transition completes

Behaviour:
- Key layout (row, col, 1-based):
  - row1: 1 2 3 A
  - row2: 4 5 6 B
  - row3: 7 8 9 C
  - row4: 0 F E D
  - e.g. key 0 = row4/col1, key 8 = row3/col2, key 6 = row2/col3, key A = row1/col4.
- Reset (iRST=0, asynchronous):
  - oROW=4'b1111, oKEYMAP=0, oBUSY=0, oSETTLED=0, oCMD_READY=0 during reset; 1 from the first clock after release.
  - LFSR=LFSR_SEED, FSM=IDLE.
- Handshake: command accepted on a rising edge with iCMD_VALID & oCMD_READY. oCMD_READY = (state==IDLE). One transition at a time; no queuing.
- FSM:
  - IDLE: on accept, latch key and direction.
    - If target state equals the current oKEYMAP bit, or BOUNCE_CYCLES==0: update oKEYMAP next cycle, pulse oSETTLED, stay IDLE.
    - Otherwise -> BOUNCE with counter=BOUNCE_CYCLES-1.
  - BOUNCE: the latched key's effective contact = LFSR bit0 each cycle. Counter decrements; at 0 -> SETTLE.
  - SETTLE (one cycle): oKEYMAP bit takes the target value, oSETTLED=1, oBUSY=0 on the next cycle, -> IDLE.
- oBUSY=1 in BOUNCE and SETTLE.
- LFSR: 16-bit Galois, taps 16,14,13,11 (mask 16'hB400); advances only in BOUNCE.
- Effective contact vector = oKEYMAP, with the transitioning key's bit overridden by LFSR bit0 while in BOUNCE.
- Row drive, registered with 1-cycle latency: oROW[r] <= ~OR over c of (contact(r,c) & ~iCOL[c]).
  - Multiple held keys are ORed; phantom keys from 3-key rectangles are not modelled.
  - iCOL=4'b1111 -> oROW=4'b1111.
- Commands are ignored while busy (READY=0); a VALID held during busy is accepted on return to IDLE.
- Reset mid-bounce: immediate abort; all keys released, oROW=4'b1111.
- Counter width is 20 bits; BOUNCE_CYCLES=1 gives exactly one chatter cycle.

Decomposition:
- Package keypad_pkg holds:
  - key-code-to-(row,col) lookup constants (16 entries).
  - FSM state encoding (IDLE, BOUNCE, SETTLE).
  - LFSR tap mask constant.
- The scanner shares the same key-code table from this package.
- One sub-module, kpm_lfsr16: enable, seed, 16-bit state output.
- Row-drive logic and FSM stay in the top.

Test Plan:
- Reset: hold iRST=0 for 20 ns with iCOL=4'b0000 -> oROW=4'b1111, oKEYMAP=0. Release -> oCMD_READY=1 the next cycle.
- Clean press, BOUNCE_CYCLES=0:
  - press key 0 -> oKEYMAP=16'h0001, oSETTLED one-cycle pulse.
  - iCOL=4'b1110 -> oROW=4'b0111 one cycle later; iCOL=4'b1101 -> oROW=4'b1111.
- Bounce, BOUNCE_CYCLES=16:
  - press key 8 -> oBUSY high exactly 17 cycles, oCMD_READY low throughout.
  - With iCOL=4'b1101, oROW[2] follows the LFSR sequence from seed ACE1.
  - Final oROW=4'b1011, oKEYMAP=16'h0100.
- Multi-key: hold keys 6 and A, iCOL=4'b0000 -> oROW=4'b1100.
  - Release A -> after settle, oROW=4'b1101, oKEYMAP=16'h0040.
- Redundant command: press already-held key 6 -> no bounce (oBUSY stays 0), oSETTLED pulse, oKEYMAP unchanged.
- Reset mid-bounce: assert iRST=0 at bounce cycle 5 -> oROW=4'b1111, oKEYMAP=0, oBUSY=0 immediately (asynchronous).
